// File: rtl/dwbuf.sv
// dwbuf: data-side write buffer between dcache and mem.
// Word writes are queued in a small circular FIFO with same-address merging
// and drained to mem one at a time over the writereq/writeval handshake.
// A combinational lookup port lets the read-miss path see buffered data.
module dwbuf #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inreq,
  input  logic [N-1:0]           inadr,
  input  logic [N-1:0]           indata,
  output logic                   inack,
  output logic                   writereq,
  output logic [N-1:0]           writeadr,
  output logic [N-1:0]           writedata,
  input  logic                   writeval,
  input  logic [N-1:0]           lkadr,
  output logic                   lkhit,
  output logic [N-1:0]           lkdata,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [N-1:0]   adr_q  [DEPTH];
  logic [N-1:0]   adr_d  [DEPTH];
  logic [N-1:0]   data_q [DEPTH];
  logic [N-1:0]   data_d [DEPTH];
  logic [AW-1:0]  head_q, head_d;
  logic [AW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  logic           writereq_q, writereq_d;
  logic [N-1:0]   writeadr_q, writeadr_d;
  logic [N-1:0]   writedata_q, writedata_d;

  logic [DEPTH-1:0] pending;
  logic             mergeHit;
  logic [AW-1:0]    mergeIdx;
  logic             lkPendHit;
  logic [N-1:0]     lkPendData;
  logic             lkHeadHit;
  logic             accept;
  logic             push;
  logic             pop;

  // An entry is pending when valid and not the head currently out on the mem bus.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pending[i] = valid_q[i] & ~((state_q == BUSY) && (head_q == AW'(i)));
    end
  end

  // Search the pending entries for a merge target and for a lookup match; at most one pending entry holds any address.
  always_comb begin
    mergeHit   = 1'b0;
    mergeIdx   = '0;
    lkPendHit  = 1'b0;
    lkPendData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pending[i] && (adr_q[i] == inadr)) begin
        mergeHit = 1'b1;
        mergeIdx = AW'(i);
      end
      if (pending[i] && (adr_q[i] == lkadr)) begin
        lkPendHit  = 1'b1;
        lkPendData = data_q[i];
      end
    end
  end

  assign lkHeadHit = (state_q == BUSY) && valid_q[head_q] && (adr_q[head_q] == lkadr);

  assign inack  = reset & ((count_q < CW'(DEPTH)) | mergeHit);
  assign accept = inreq & inack;
  assign push   = accept & ~mergeHit;
  assign pop    = (state_q == BUSY) & writeval;

  assign lkhit  = lkPendHit | lkHeadHit;
  assign lkdata = lkPendHit ? lkPendData : (lkHeadHit ? data_q[head_q] : '0);

  assign writereq  = writereq_q;
  assign writeadr  = writeadr_q;
  assign writedata = writedata_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);

  // Next-state for the FIFO contents, pointers, count and the drain FSM.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    adr_d       = adr_q;
    data_d      = data_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    writereq_d  = writereq_q;
    writeadr_d  = writeadr_q;
    writedata_d = writedata_q;

    if (accept) begin
      if (mergeHit) begin
        data_d[mergeIdx] = indata;
      end else begin
        valid_d[tail_q] = 1'b1;
        adr_d[tail_q]   = inadr;
        data_d[tail_q]  = indata;
        tail_d          = tail_q + AW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          writereq_d = 1'b1;
          writeadr_d = adr_q[head_q];
          // A merge into the head on the very edge it is issued must reach mem, not be lost.
          if (accept && mergeHit && (mergeIdx == head_q)) begin
            writedata_d = indata;
          end else begin
            writedata_d = data_q[head_q];
          end
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (writeval) begin
          valid_d[head_q] = 1'b0;
          head_d          = head_q + AW'(1);
          writereq_d      = 1'b0;
          state_d         = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        writereq_d = 1'b0;
      end
    endcase

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state and the mem request registers, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      writereq_q  <= 1'b0;
      writeadr_q  <= '0;
      writedata_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      writereq_q  <= writereq_d;
      writeadr_q  <= writeadr_d;
      writedata_q <= writedata_d;
    end
  end

  // Entry payload needs no reset: it is only ever observed through a valid bit.
  always_ff @(posedge clk) begin
    adr_q  <= adr_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_dwbuf.sv
// tb_dwbuf: directed bench for dwbuf with a scoreboard of expected mem writes.
// Stimulus pushes hand-computed expected writes; a mem model pops and compares
// each time it completes a write with writeval.
module tb_dwbuf;

  localparam int N     = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [N-1:0] adr;
    logic [N-1:0] data;
  } wr_t;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   inreq = 1'b0;
  logic [N-1:0]           inadr = '0;
  logic [N-1:0]           indata = '0;
  logic                   inack;
  logic                   writereq;
  logic [N-1:0]           writeadr;
  logic [N-1:0]           writedata;
  logic                   writeval;
  logic [N-1:0]           lkadr = '0;
  logic                   lkhit;
  logic [N-1:0]           lkdata;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;

  logic memVal = 1'b0;
  logic strayVal = 1'b0;
  assign writeval = memVal | strayVal;

  int  checks = 0;
  int  passes = 0;
  int  memLatency = 3;
  bit  memStall = 1'b1;
  int  pulseReqCnt = 0;
  wr_t expQ[$];

  dwbuf #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .inreq(inreq), .inadr(inadr), .indata(indata), .inack(inack),
    .writereq(writereq), .writeadr(writeadr), .writedata(writedata), .writeval(writeval),
    .lkadr(lkadr), .lkhit(lkhit), .lkdata(lkdata),
    .empty(empty), .count(count)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [N-1:0] actual, input logic [N-1:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] adr, input logic [N-1:0] data);
    inreq  = 1'b1;
    inadr  = adr;
    indata = data;
    #1;
  endtask

  task automatic pushExp(input logic [N-1:0] adr, input logic [N-1:0] data);
    expQ.push_back('{adr: adr, data: data});
  endtask

  task automatic writeWord(input logic [N-1:0] adr, input logic [N-1:0] data);
    int k = 0;
    applyStimulus(adr, data);
    while (!inack && k < 40) begin
      cyc(1);
      k++;
    end
    if (!inack) begin
      checks++;
      $display("[TB] FAIL accept_timeout: got inack 0, want 1 for adr %h", adr);
    end
    cyc(1);
    inreq = 1'b0;
  endtask

  task automatic waitDrained(input string name);
    int k = 0;
    while (!(empty && !writereq) && k < 200) begin
      cyc(1);
      k++;
    end
    checkOutput({name, "_empty"}, 32'(empty), 32'd1);
    checkOutput({name, "_writereq"}, 32'(writereq), 32'd0);
    checkOutput({name, "_sb_left"}, 32'(expQ.size()), 32'd0);
  endtask

  // Mem model: completes the current request after memLatency cycles, or at once on a manual pulse request.
  initial begin : memModel
    wr_t e;
    int  waitCnt;
    int  pulseDone;
    waitCnt   = 0;
    pulseDone = 0;
    forever begin
      @(negedge clk);
      memVal = 1'b0;
      if (writereq) begin
        if ((pulseDone < pulseReqCnt) || (!memStall && (waitCnt + 1 >= memLatency))) begin
          if (pulseDone < pulseReqCnt) pulseDone++;
          waitCnt = 0;
          memVal  = 1'b1;
          if (expQ.size() == 0) begin
            checks++;
            $display("[TB] FAIL mem_unexpected: got write adr %h, want none", writeadr);
          end else begin
            e = expQ.pop_front();
            checkOutput("mem_adr", writeadr, e.adr);
            checkOutput("mem_data", writedata, e.data);
          end
        end else if (!memStall) begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  // Hard stop in case something never settles.
  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin : stimulus
    int simSeen;
    logic [$clog2(DEPTH):0] cb;
    bit sim;
    int k;
    simSeen = 0;

    // Reset values
    lkadr = 32'h40;
    cyc(2);
    checkOutput("rst_writereq", 32'(writereq), 32'd0);
    checkOutput("rst_writeadr", writeadr, 32'd0);
    checkOutput("rst_writedata", writedata, 32'd0);
    checkOutput("rst_inack", 32'(inack), 32'd0);
    checkOutput("rst_lkhit", 32'(lkhit), 32'd0);
    checkOutput("rst_lkdata", lkdata, 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_count", 32'(count), 32'd0);

    // Single write, mem answers three cycles after the request rises
    reset = 1'b1;
    memLatency = 3;
    memStall = 1'b0;
    pushExp(32'h40, 32'hDEADBEEF);
    applyStimulus(32'h40, 32'hDEADBEEF);
    checkOutput("single_inack", 32'(inack), 32'd1);
    cyc(1);
    inreq = 1'b0;
    checkOutput("single_count", 32'(count), 32'd1);
    checkOutput("single_lkhit", 32'(lkhit), 32'd1);
    checkOutput("single_lkdata", lkdata, 32'hDEADBEEF);
    checkOutput("single_req_early", 32'(writereq), 32'd0);
    cyc(1);
    checkOutput("single_req", 32'(writereq), 32'd1);
    checkOutput("single_adr", writeadr, 32'h40);
    checkOutput("single_data", writedata, 32'hDEADBEEF);
    waitDrained("single");

    // Fill with mem stalled, merge while full, then one completion frees a slot
    memStall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'(4 * i), 32'h100 + 32'(i));
      checkOutput("fill_inack", 32'(inack), 32'd1);
      cyc(1);
    end
    applyStimulus(32'h10, 32'h104);
    checkOutput("fill_count", 32'(count), 32'd4);
    checkOutput("fill_full_inack", 32'(inack), 32'd0);
    applyStimulus(32'h08, 32'h999);
    checkOutput("fill_merge_inack", 32'(inack), 32'd1);
    cyc(1);
    checkOutput("fill_merge_count", 32'(count), 32'd4);
    pushExp(32'h00, 32'h100);
    pushExp(32'h04, 32'h101);
    pushExp(32'h08, 32'h999);
    pushExp(32'h0C, 32'h103);
    pushExp(32'h10, 32'h104);
    applyStimulus(32'h10, 32'h104);
    checkOutput("fill_full_inack2", 32'(inack), 32'd0);
    pulseReqCnt++;
    cyc(1);
    checkOutput("fill_pulse_inack", 32'(inack), 32'd0);
    cyc(1);
    checkOutput("fill_after_count", 32'(count), 32'd3);
    checkOutput("fill_after_inack", 32'(inack), 32'd1);
    cyc(1);
    inreq = 1'b0;
    checkOutput("fill_refill_count", 32'(count), 32'd4);
    memLatency = 1;
    memStall = 1'b0;
    waitDrained("fill");

    // Merge into a pending entry, never into the in-flight head; lookup priority
    memStall = 1'b1;
    pushExp(32'h00, 32'hAAAA);
    applyStimulus(32'h00, 32'hAAAA);
    cyc(1);
    applyStimulus(32'h04, 32'h1111);
    cyc(1);
    checkOutput("merge_count2", 32'(count), 32'd2);
    checkOutput("merge_inflight", 32'(writereq), 32'd1);
    applyStimulus(32'h04, 32'h2222);
    checkOutput("merge_inack", 32'(inack), 32'd1);
    cyc(1);
    checkOutput("merge_count_kept", 32'(count), 32'd2);
    pushExp(32'h04, 32'h2222);
    applyStimulus(32'h00, 32'h3333);
    cyc(1);
    inreq = 1'b0;
    checkOutput("merge_head_alloc", 32'(count), 32'd3);
    pushExp(32'h00, 32'h3333);
    lkadr = 32'h00;
    #1;
    checkOutput("lk_prio_hit", 32'(lkhit), 32'd1);
    checkOutput("lk_prio_data", lkdata, 32'h3333);
    lkadr = 32'h80;
    #1;
    checkOutput("lk_miss_hit", 32'(lkhit), 32'd0);
    checkOutput("lk_miss_data", lkdata, 32'd0);
    lkadr = 32'h04;
    #1;
    checkOutput("lk_merged_data", lkdata, 32'h2222);
    memLatency = 2;
    memStall = 1'b0;
    waitDrained("merge");

    // Ten writes with mem acking immediately: pointer wrap and push/pop on one edge
    memLatency = 1;
    memStall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pushExp(32'h200 + 32'(4 * i), 32'h5A000000 + 32'(i));
      applyStimulus(32'h200 + 32'(4 * i), 32'h5A000000 + 32'(i));
      k = 0;
      while (!inack && k < 40) begin
        cyc(1);
        k++;
      end
      if (!inack) begin
        checks++;
        $display("[TB] FAIL wrap_accept_timeout: got inack 0, want 1 for write %0d", i);
      end
      sim = writeval && inack;
      cb  = count;
      cyc(1);
      inreq = 1'b0;
      if (sim) begin
        simSeen++;
        checkOutput("pushpop_count", 32'(count), 32'(cb));
      end
    end
    checkOutput("pushpop_seen", 32'(simSeen != 0), 32'd1);
    waitDrained("wrap");

    // Reset while a write is in flight with three entries buffered
    memStall = 1'b1;
    writeWord(32'h300, 32'h1);
    writeWord(32'h304, 32'h2);
    writeWord(32'h308, 32'h3);
    k = 0;
    while (!writereq && k < 20) begin
      cyc(1);
      k++;
    end
    checkOutput("rstmid_busy", 32'(writereq), 32'd1);
    checkOutput("rstmid_count3", 32'(count), 32'd3);
    reset = 1'b0;
    applyStimulus(32'h30C, 32'h4);
    checkOutput("rstmid_inack_low", 32'(inack), 32'd0);
    cyc(1);
    checkOutput("rstmid_writereq", 32'(writereq), 32'd0);
    checkOutput("rstmid_count", 32'(count), 32'd0);
    checkOutput("rstmid_empty", 32'(empty), 32'd1);
    checkOutput("rstmid_inack", 32'(inack), 32'd0);
    lkadr = 32'h300;
    #1;
    checkOutput("rstmid_lkhit", 32'(lkhit), 32'd0);
    reset = 1'b1;
    inreq = 1'b0;
    strayVal = 1'b1;
    cyc(1);
    strayVal = 1'b0;
    checkOutput("stray_count", 32'(count), 32'd0);
    checkOutput("stray_empty", 32'(empty), 32'd1);
    checkOutput("stray_writereq", 32'(writereq), 32'd0);
    cyc(2);
    checkOutput("stray_writereq_late", 32'(writereq), 32'd0);
    checkOutput("stray_count_late", 32'(count), 32'd0);
    checkOutput("final_sb_left", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
